// File: rtl/intc_bamse.sv
// intc_bamse: edge-capturing interrupt controller for the PicoBlaze port bus (optional macro INTC_VECTOR_EN).
// Latency: source edge -> pend next cycle -> interrupt high in the third cycle; register writes take effect next cycle.
// Backpressure: none; a raised interrupt is held until interrupt_ack, later edges stay pending.
module intc_bamse #(
  parameter int          N_SRC     = 8,
  parameter logic [7:0]  ADDR_PEND = 8'h01,
  parameter logic [7:0]  ADDR_MASK = 8'h02,
  parameter logic [7:0]  ADDR_VEC  = 8'h03
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [7:0]       address,
  input  logic [7:0]       data_in,
  input  logic             ren,
  input  logic             wen,
  output logic [7:0]       data_out,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] pend_clr;
  logic [7:0]       pend_x;
  logic [7:0]       mask_x;
  logic [7:0]       vec_x;
  logic             svc_done;
  logic             unused_ok;

  // Reads have no side effects, so the strobe and any data bits beyond N_SRC are not needed.
  assign unused_ok = ren ^ (^data_in);

  assign edges    = irq_src & ~irq_q;
  assign act      = pend & mask;
  assign pend_clr = (wen && address == ADDR_PEND) ? data_in[N_SRC-1:0] : '0;
  assign pend_x   = 8'(pend);
  assign mask_x   = 8'(mask);

  // Source history, pending capture (a new edge beats a same-cycle clear) and mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= '0;
      pend  <= '0;
      mask  <= '0;
    end else begin
      irq_q <= irq_src;
      pend  <= (pend & ~pend_clr) | edges;
      if (wen && address == ADDR_MASK)
        mask <= data_in[N_SRC-1:0];
    end
  end

`ifdef INTC_VECTOR_EN
  logic [2:0] vec;
  logic [2:0] idx;

  // Lowest-index active source wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (act[i]) idx = 3'(i);
  end

  // Vector is frozen when the request is raised so software sees which source it is serving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vec <= 3'd0;
    else if (state == IDLE && act != '0)
      vec <= idx;
  end

  assign vec_x    = {5'b0, vec};
  assign svc_done = ~pend_x[vec];
`else
  assign vec_x    = 8'h00;
  assign svc_done = (act == '0);
`endif

  // Software register read mux, unmapped addresses read zero.
  always_comb begin
    data_out = 8'h00;
    if (address == ADDR_PEND)
      data_out = pend_x;
    else if (address == ADDR_MASK)
      data_out = mask_x;
    else if (address == ADDR_VEC)
      data_out = vec_x;
  end

  // Handshake sequencing: a raised request is never retracted, only acknowledged.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (act != '0)    state_nxt = REQ;
      REQ:     if (interrupt_ack) state_nxt = SERVICE;
      SERVICE: if (svc_done)      state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State register plus the registered interrupt line, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nxt;
      interrupt <= (state_nxt == REQ);
    end
  end

endmodule
